// File: rtl/gray_sweep_ctrl.sv
`timescale 1ns/1ps
// Sweep sequencer for a binary-to-gray converter: drives every code, waits SETTLE cycles,
// and hands each {bin,gray} pair out over valid/ready. Define GRAY_SWEEP_CHECK_EN for the sticky err comparator.
module gray_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             cont,
    input  logic             abort,
    output logic [WIDTH-1:0] bin_o,
    input  logic [WIDTH-1:0] gray_i,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic [WIDTH-1:0] out_gray,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Capture happens on the edge that closes the SETTLE-th cycle after bin_o moved.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] out_bin_q, out_bin_d;
    logic [WIDTH-1:0] out_gray_q, out_gray_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             cont_q, cont_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             hs;

`ifdef GRAY_SWEEP_CHECK_EN
    logic             err_q, err_d;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction
`endif

    assign hs = valid_q & out_ready;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        out_bin_d  = out_bin_q;
        out_gray_d = out_gray_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        cont_d     = cont_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
`ifdef GRAY_SWEEP_CHECK_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SETTLE;
                    bin_d   = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                    cnt_d   = 4'd0;
                    dir_d   = dir;
                    cont_d  = cont;
                    code_d  = '0;
`ifdef GRAY_SWEEP_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    out_bin_d  = bin_q;
                    out_gray_d = gray_i;
                    valid_d    = 1'b1;
                    state_d    = S_HOLD;
`ifdef GRAY_SWEEP_CHECK_EN
                    if (gray_i != to_gray(bin_q)) begin
                        err_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (hs) begin
                    valid_d = 1'b0;
                    code_d  = code_q + WIDTH'(1);
                    // code_q counts pairs already accepted, so all-ones means this was the last one.
                    if (!cont_q && (code_q == {WIDTH{1'b1}})) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bin_d   = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
                        state_d = S_SETTLE;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            out_bin_q  <= '0;
            out_gray_q <= '0;
            code_q     <= '0;
            cnt_q      <= 4'd0;
            dir_q      <= 1'b0;
            cont_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef GRAY_SWEEP_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            out_bin_q  <= out_bin_d;
            out_gray_q <= out_gray_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            cont_q     <= cont_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
`ifdef GRAY_SWEEP_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign bin_o     = bin_q;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = valid_q;
    assign out_bin   = out_bin_q;
    assign out_gray  = out_gray_q;
    assign done      = done_q;
`ifdef GRAY_SWEEP_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
`timescale 1ns/1ps
// Directed-plus-random bench for gray_sweep_ctrl: an ideal (optionally corrupted) converter
// feeds gray_i, and expected pairs come from sweep arithmetic on the pair index.
module tb_gray_sweep_ctrl;
    localparam int W    = 4;
    localparam int ST   = 2;
    localparam int N    = 1 << W;
    localparam int MAXV = N - 1;
`ifdef GRAY_SWEEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, dir, cont, abort, out_ready;
    logic [W-1:0] bin_o, gray_i, out_bin, out_gray;
    logic         busy, out_valid, done, err;

    int           checks = 0;
    int           errors = 0;
    logic         corrupt_en = 1'b0;
    logic [W-1:0] corrupt_code = '0;
    bit           exp_err = 1'b0;

    always #5 clk = ~clk;

    // Ideal converter written bitwise: g[i] = b[i] xor b[i+1], top bit passes through.
    function automatic logic [W-1:0] conv_gray(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    assign gray_i = (corrupt_en && bin_o == corrupt_code) ? '0 : conv_gray(bin_o);

    gray_sweep_ctrl #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .cont      (cont),
        .abort     (abort),
        .bin_o     (bin_o),
        .gray_i    (gray_i),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_gray  (out_gray),
        .done      (done),
        .err       (err)
    );

    // k-th code of a sweep: counts up from 0 or down from all-ones, wrapping mod 2^W.
    function automatic int exp_code(input bit d, input int k);
        int m;
        m = k % N;
        return d ? (MAXV - m) : m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input bit d, input bit c, input int first_code);
        start = 1'b1; dir = d; cont = c; abort = 1'b0;
        @(negedge clk);
        start = 1'b0; dir = ~d; cont = ~c;
        exp_err = 1'b0;
        check("start_bin", bin_o, first_code);
        check("start_busy", busy, 1);
        check("start_valid", out_valid, 0);
        check("start_done", done, 0);
        check("start_err", err, exp_err);
    endtask

    // Waits for pair k, checks it, holds it for 'hold' cycles, then accepts it.
    task automatic get_pair(input bit d, input bit c, input int k, input int hold);
        int  n;
        int  ev, eg;
        bit  last;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        ev = exp_code(d, k);
        eg = (corrupt_en && ev == int'(corrupt_code)) ? 0 : (ev ^ (ev >> 1));
        if (CHK && eg != (ev ^ (ev >> 1))) exp_err = 1'b1;
        check("latency", n, ST);
        check("pair_bin", out_bin, ev);
        check("pair_gray", out_gray, eg);
        check("pair_bin_o", bin_o, ev);
        check("pair_err", err, exp_err);
        for (int h = 0; h < hold; h++) begin
            start = 1'(($urandom_range(0, 1)));
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_bin", out_bin, ev);
            check("hold_gray", out_gray, eg);
            check("hold_bin_o", bin_o, ev);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        last = !c && (k == N - 1);
        check("acc_valid", out_valid, 0);
        check("acc_done", done, last);
        check("acc_busy", busy, !last);
        check("acc_bin_o", bin_o, last ? ev : exp_code(d, k + 1));
        check("acc_err", err, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; dir = 1'b0; cont = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_bin_o", bin_o, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_out_bin", out_bin, 0);
        check("rst_out_gray", out_gray, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Single upward sweep, consumer always ready.
        do_start(1'b0, 1'b0, 0);
        for (int k = 0; k < N; k++) get_pair(1'b0, 1'b0, k, 0);
        @(negedge clk);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_bin_o", bin_o, MAXV);

        // Continuous downward sweep across the 0 -> all-ones wrap, random backpressure.
        do_start(1'b1, 1'b1, MAXV);
        for (int k = 0; k < N + 2; k++) get_pair(1'b1, 1'b1, k, $urandom_range(0, 2));
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wrap_latency", n, ST);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("hold_abort_busy", busy, 0);
        check("hold_abort_valid", out_valid, 0);
        check("hold_abort_done", done, 0);
        check("hold_abort_bin_o", bin_o, exp_code(1'b1, N + 2));
        check("hold_abort_out_bin", out_bin, exp_code(1'b1, N + 2));
        check("hold_abort_out_gray", out_gray, exp_code(1'b1, N + 2) ^ (exp_code(1'b1, N + 2) >> 1));

        // Long stall on code 5, then abort together with start during SETTLE of code 9.
        do_start(1'b0, 1'b0, 0);
        for (int k = 0; k < 9; k++) get_pair(1'b0, 1'b0, k, (k == 5) ? 7 : 0);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        check("abort_bin_o", bin_o, 9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_quiet_valid", out_valid, 0);
            check("abort_quiet_done", done, 0);
        end
        do_start(1'b0, 1'b0, 0);
        for (int k = 0; k < 3; k++) get_pair(1'b0, 1'b0, k, $urandom_range(0, 1));

        // Asynchronous reset in the middle of a clock cycle.
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_bin_o", bin_o, 0);
        check("arst_out_bin", out_bin, 0);
        check("arst_out_gray", out_gray, 0);
        check("arst_valid", out_valid, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_idle_busy", busy, 0);
        check("arst_idle_done", done, 0);

        // Converter fault at code 3: captured as-is, err sticky only with the checker built.
        corrupt_code = 3;
        corrupt_en = 1'b1;
        do_start(1'b0, 1'b0, 0);
        for (int k = 0; k < N; k++) get_pair(1'b0, 1'b0, k, $urandom_range(0, 2));
        @(negedge clk);
        check("fault_err_idle", err, exp_err);
        check("fault_err_set", exp_err, CHK);
        corrupt_en = 1'b0;
        do_start(1'b1, 1'b0, MAXV);
        get_pair(1'b1, 1'b0, 0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("final_busy", busy, 0);
        check("final_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
